// File: rtl/ocm_amo_pkg.sv
// Shared op codes, FSM encoding and SC result values for the OCM atomic sequencer.
package ocm_amo_pkg;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_SWAP  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_MIN   = 4'd7;
    localparam logic [3:0] OP_MAX   = 4'd8;
    localparam logic [3:0] OP_MINU  = 4'd9;
    localparam logic [3:0] OP_MAXU  = 4'd10;
    localparam logic [3:0] OP_LR    = 4'd11;
    localparam logic [3:0] OP_SC    = 4'd12;

    localparam logic [31:0] SC_OK   = 32'd0;
    localparam logic [31:0] SC_FAIL = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2
    } state_t;

endpackage

// File: rtl/ocm_amo_alu.sv
// Combinational read-modify-write datapath: computes the new word and whether the op writes.
// SC is reported as non-writing here; the sequencer qualifies it with the reservation check.
module ocm_amo_alu
    import ocm_amo_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_new,
    output logic        o_we
);

    always_comb begin
        o_new = i_old;
        o_we  = 1'b0;
        case (i_op)
            OP_STORE, OP_SWAP: begin o_new = i_wdata;           o_we = 1'b1; end
            OP_ADD:            begin o_new = i_old + i_wdata;   o_we = 1'b1; end
            OP_AND:            begin o_new = i_old & i_wdata;   o_we = 1'b1; end
            OP_OR:             begin o_new = i_old | i_wdata;   o_we = 1'b1; end
            OP_XOR:            begin o_new = i_old ^ i_wdata;   o_we = 1'b1; end
            OP_MIN: begin
                o_new = ($signed(i_old) < $signed(i_wdata)) ? i_old : i_wdata;
                o_we  = 1'b1;
            end
            OP_MAX: begin
                o_new = ($signed(i_old) > $signed(i_wdata)) ? i_old : i_wdata;
                o_we  = 1'b1;
            end
            OP_MINU: begin o_new = (i_old < i_wdata) ? i_old : i_wdata; o_we = 1'b1; end
            OP_MAXU: begin o_new = (i_old > i_wdata) ? i_old : i_wdata; o_we = 1'b1; end
            OP_SC:   begin o_new = i_wdata; o_we = 1'b0; end
            default: begin o_new = i_old;   o_we = 1'b0; end
        endcase
    end

endmodule

// File: rtl/ocm_amo_sequencer.sv
// Two-core atomic-op sequencer owning one OCM port: IDLE -> RD -> EX per op, round-robin grant.
// Define OCM_AMO_LRSC_EN to compile in per-core LR/SC reservations.
module ocm_amo_sequencer
    import ocm_amo_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req_1,
    input  logic [3:0]           i_op_1,
    input  logic [ADDR_BITS-1:0] i_addr_1,
    input  logic [31:0]          i_wdata_1,
    output logic                 o_ack_1,
    output logic [31:0]          o_rdata_1,
    input  logic                 i_req_2,
    input  logic [3:0]           i_op_2,
    input  logic [ADDR_BITS-1:0] i_addr_2,
    input  logic [31:0]          i_wdata_2,
    output logic                 o_ack_2,
    output logic [31:0]          o_rdata_2,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [31:0]          o_mem_wdata,
    output logic [3:0]           o_mem_we,
    input  logic [31:0]          i_mem_rdata
);

    state_t                 r_state, w_next;
    logic                   r_win;   // 0: core 1, 1: core 2
    logic                   r_last;  // core last granted, same encoding
    logic [3:0]             r_op;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata_1, r_rdata_2;

    logic                   w_any, w_gnt2, w_ex, w_we, w_sc_ok, w_alu_we;
    logic [31:0]            w_alu_new, w_result;

    assign w_any  = i_req_1 | i_req_2;
    // Core 2 wins when alone, or when both request and core 1 was served last.
    assign w_gnt2 = i_req_2 & (~i_req_1 | ~r_last);
    assign w_ex   = (r_state == ST_EX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next = ST_RD;
            ST_RD:   w_next = ST_EX;
            ST_EX:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_win   <= 1'b0;
            r_last  <= 1'b1;
            r_op    <= OP_LOAD;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_any) begin
                r_win   <= w_gnt2;
                r_last  <= w_gnt2;
                r_op    <= w_gnt2 ? i_op_2    : i_op_1;
                r_addr  <= w_gnt2 ? i_addr_2  : i_addr_1;
                r_wdata <= w_gnt2 ? i_wdata_2 : i_wdata_1;
            end
        end
    end

    ocm_amo_alu u_alu (
        .i_op    (r_op),
        .i_old   (i_mem_rdata),
        .i_wdata (r_wdata),
        .o_new   (w_alu_new),
        .o_we    (w_alu_we)
    );

`ifdef OCM_AMO_LRSC_EN
    logic [1:0]                r_rsv_vld;
    logic [1:0][ADDR_BITS-1:0] r_rsv_addr;

    assign w_sc_ok = r_rsv_vld[r_win] && (r_rsv_addr[r_win] == r_addr);

    // Later assignments win: a core's own LR/SC update overrides the snoop clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsv_vld  <= '0;
            r_rsv_addr <= '0;
        end else if (w_ex) begin
            for (int c = 0; c < 2; c++)
                if (w_we && r_rsv_addr[c] == r_addr) r_rsv_vld[c] <= 1'b0;
            if (r_op == OP_LR) begin
                r_rsv_vld[r_win]  <= 1'b1;
                r_rsv_addr[r_win] <= r_addr;
            end else if (r_op == OP_SC) begin
                r_rsv_vld[r_win]  <= 1'b0;
            end
        end
    end
`else
    assign w_sc_ok = 1'b0;
`endif

    assign w_we = w_ex & (w_alu_we | ((r_op == OP_SC) & w_sc_ok));

    always_comb begin
        w_result = i_mem_rdata;
        if (r_op == OP_SC)     w_result = w_sc_ok ? SC_OK : SC_FAIL;
        else if (r_op > OP_SC) w_result = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_1 <= '0;
            r_rdata_2 <= '0;
        end else if (w_ex) begin
            if (r_win) r_rdata_2 <= w_result;
            else       r_rdata_1 <= w_result;
        end
    end

    // Result is visible combinationally in the ack cycle, then held in the register.
    assign o_ack_1     = w_ex & ~r_win;
    assign o_ack_2     = w_ex &  r_win;
    assign o_rdata_1   = o_ack_1 ? w_result : r_rdata_1;
    assign o_rdata_2   = o_ack_2 ? w_result : r_rdata_2;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = w_ex ? w_alu_new : 32'd0;
    assign o_mem_we    = w_we ? 4'hF : 4'h0;

endmodule

// File: tb/tb_ocm_amo_sequencer.sv
// Directed bench for ocm_amo_sequencer with a behavioural one-cycle-latency OCM model.
module tb_ocm_amo_sequencer;
    import ocm_amo_pkg::*;

`ifdef OCM_AMO_LRSC_EN
    localparam bit LRSC = 1'b1;
`else
    localparam bit LRSC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req_1 = 1'b0, i_req_2 = 1'b0;
    logic [3:0]  i_op_1 = '0, i_op_2 = '0;
    logic [11:0] i_addr_1 = '0, i_addr_2 = '0;
    logic [31:0] i_wdata_1 = '0, i_wdata_2 = '0;
    logic        o_ack_1, o_ack_2;
    logic [31:0] o_rdata_1, o_rdata_2;
    logic [11:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:4095];
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [31:0] poke_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= mem[o_mem_addr];
        if (poke_en)              mem[poke_addr]  <= poke_data;
        else if (o_mem_we == 4'hF) mem[o_mem_addr] <= o_mem_wdata;
    end

    ocm_amo_sequencer #(.ADDR_BITS(12)) dut (
        .clk(clk), .rst(rst),
        .i_req_1(i_req_1), .i_op_1(i_op_1), .i_addr_1(i_addr_1), .i_wdata_1(i_wdata_1),
        .o_ack_1(o_ack_1), .o_rdata_1(o_rdata_1),
        .i_req_2(i_req_2), .i_op_2(i_op_2), .i_addr_2(i_addr_2), .i_wdata_2(i_wdata_2),
        .o_ack_2(o_ack_2), .o_rdata_2(o_rdata_2),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
        .i_mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Counts posedges until the core's ack is seen (-1 on timeout).
    task automatic wait_ack(input int core, output int cyc, output logic [31:0] rd);
        bit got = 1'b0;
        cyc = 0; rd = '0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(posedge clk); #1;
            cyc++;
            if ((core == 1) ? o_ack_1 : o_ack_2) begin
                got = 1'b1;
                rd  = (core == 1) ? o_rdata_1 : o_rdata_2;
            end
        end
        if (!got) cyc = -1;
    endtask

    task automatic run_op(input int core, input logic [3:0] op, input logic [11:0] a,
                          input logic [31:0] wd, output logic [31:0] rd);
        int cyc;
        @(negedge clk);
        if (core == 1) begin i_req_1 = 1'b1; i_op_1 = op; i_addr_1 = a; i_wdata_1 = wd; end
        else           begin i_req_2 = 1'b1; i_op_2 = op; i_addr_2 = a; i_wdata_2 = wd; end
        wait_ack(core, cyc, rd);
        check("ack_latency", cyc, 2);
        if (core == 1) i_req_1 = 1'b0; else i_req_2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alu_case(input string tag, input logic [3:0] op, input logic [11:0] a,
                            input logic [31:0] old, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic [31:0] exp_mem);
        logic [31:0] rd;
        poke(a, old);
        run_op(2, op, a, wd, rd);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_mem"}, mem[a], exp_mem);
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;

        // Reset values while rst is held
        repeat (2) @(negedge clk);
        check("rst_ack_1", {31'd0, o_ack_1}, 32'd0);
        check("rst_ack_2", {31'd0, o_ack_2}, 32'd0);
        check("rst_rdata_1", o_rdata_1, 32'd0);
        check("rst_rdata_2", o_rdata_2, 32'd0);
        check("rst_mem_we", {28'd0, o_mem_we}, 32'd0);
        check("rst_mem_addr", {20'd0, o_mem_addr}, 32'd0);
        check("rst_mem_wdata", o_mem_wdata, 32'd0);
        rst = 1'b0;

        // ADD: old 5 + 3
        poke(12'h010, 32'd5);
        run_op(1, OP_ADD, 12'h010, 32'd3, rd);
        check("add_rdata", rd, 32'd5);
        check("add_mem", mem[12'h010], 32'd8);

        // Simultaneous SWAP after reset: core 1 first, then core 2
        do_reset();
        poke(12'h020, 32'h11);
        @(negedge clk);
        i_req_1 = 1'b1; i_op_1 = OP_SWAP; i_addr_1 = 12'h020; i_wdata_1 = 32'hAAAA;
        i_req_2 = 1'b1; i_op_2 = OP_SWAP; i_addr_2 = 12'h020; i_wdata_2 = 32'hBBBB;
        wait_ack(1, cyc, rd);
        check("swap1_latency", cyc, 2);
        check("swap1_no_ack2", {31'd0, o_ack_2}, 32'd0);
        check("swap1_rdata", rd, 32'h11);
        i_req_1 = 1'b0;
        wait_ack(2, cyc, rd);
        check("swap2_latency", cyc, 3);
        check("swap2_rdata", rd, 32'hAAAA);
        check("swap2_rdata1_hold", o_rdata_1, 32'h11);
        i_req_2 = 1'b0;
        @(posedge clk); @(negedge clk);
        check("swap_mem", mem[12'h020], 32'hBBBB);

        // LR by core 1, intervening STORE by core 2, SC by core 1 fails
        poke(12'h030, 32'd0);
        run_op(1, OP_LR, 12'h030, 32'd0, rd);
        check("lr_rdata", rd, 32'd0);
        run_op(2, OP_STORE, 12'h030, 32'h1234, rd);
        check("store_rdata", rd, 32'd0);
        run_op(1, OP_SC, 12'h030, 32'h9999, rd);
        check("sc_snooped_rdata", rd, 32'd1);
        check("sc_snooped_mem", mem[12'h030], 32'h1234);

        // LR/SC pair, then a second SC
        poke(12'h040, 32'd0);
        run_op(1, OP_LR, 12'h040, 32'd0, rd);
        run_op(1, OP_SC, 12'h040, 32'hA5, rd);
        check("sc1_rdata", rd, LRSC ? 32'd0 : 32'd1);
        check("sc1_mem", mem[12'h040], LRSC ? 32'hA5 : 32'd0);
        run_op(1, OP_SC, 12'h040, 32'h5A, rd);
        check("sc2_rdata", rd, 32'd1);
        check("sc2_mem", mem[12'h040], LRSC ? 32'hA5 : 32'd0);

        // ALU functions
        alu_case("min",   OP_MIN,   12'h050, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        alu_case("minu",  OP_MINU,  12'h051, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd1);
        alu_case("max",   OP_MAX,   12'h052, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5);
        alu_case("maxu",  OP_MAXU,  12'h053, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF);
        alu_case("addw",  OP_ADD,   12'h054, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd1);
        alu_case("and",   OP_AND,   12'h055, 32'hF0F01234, 32'hFF00FF00, 32'hF0F01234, 32'hF0001200);
        alu_case("or",    OP_OR,    12'h056, 32'h0F0F0000, 32'h000000FF, 32'h0F0F0000, 32'h0F0F00FF);
        alu_case("xor",   OP_XOR,   12'h057, 32'hFFFF0000, 32'h0F0F0F0F, 32'hFFFF0000, 32'hF0F00F0F);
        alu_case("load",  OP_LOAD,  12'h058, 32'h00001111, 32'hDEAD, 32'h00001111, 32'h00001111);
        alu_case("illeg", 4'd14,    12'h059, 32'h00002222, 32'hDEAD, 32'd0, 32'h00002222);

        // Inputs changed and request dropped before ack: op still completes as latched
        poke(12'h070, 32'd10);
        poke(12'h071, 32'h55);
        @(negedge clk);
        i_req_2 = 1'b1; i_op_2 = OP_ADD; i_addr_2 = 12'h070; i_wdata_2 = 32'd1;
        @(posedge clk); #1;
        i_req_2 = 1'b0; i_op_2 = OP_STORE; i_addr_2 = 12'h071; i_wdata_2 = 32'd100;
        wait_ack(2, cyc, rd);
        check("late_change_latency", cyc, 1);
        check("late_change_rdata", rd, 32'd10);
        @(posedge clk); @(negedge clk);
        check("late_change_mem", mem[12'h070], 32'd11);
        check("late_change_other", mem[12'h071], 32'h55);

        // Reset in the EX cycle of a STORE
        poke(12'h060, 32'h33);
        @(negedge clk);
        i_req_1 = 1'b1; i_op_1 = OP_STORE; i_addr_1 = 12'h060; i_wdata_1 = 32'h77;
        @(posedge clk); @(posedge clk); #1;
        check("ex_we_before_rst", {28'd0, o_mem_we}, 32'hF);
        rst = 1'b1;
        #1;
        check("rst_ex_we", {28'd0, o_mem_we}, 32'd0);
        check("rst_ex_ack", {31'd0, o_ack_1}, 32'd0);
        i_req_1 = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("rst_ex_mem", mem[12'h060], 32'h33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
